// File: rtl/cam_pixel_capture_pkg.sv
// Shared constants and pixel helpers for the camera capture front end.
// Geometry defaults match a VGA sensor; the 565->888 expansion replicates MSBs into the low bits.
package cam_pixel_capture_pkg;

  localparam int DEFAULT_IMG_W       = 640;
  localparam int DEFAULT_IMG_H       = 480;
  localparam int DEFAULT_SKIP_FRAMES = 2;

  function automatic logic [23:0] rgb565_to_888(input logic [15:0] w);
    return {w[15:11], w[15:13], w[10:5], w[10:9], w[4:0], w[4:2]};
  endfunction

endpackage

// File: rtl/cam_pixel_capture.sv
// Byte-pair pixel capture from a DVP-style sensor: skips the first frames after init,
// packs RGB565 pixels, expands them to 888 and flags line/frame geometry errors.
module cam_pixel_capture
  import cam_pixel_capture_pkg::*;
#(
  parameter int IMG_W       = DEFAULT_IMG_W,
  parameter int IMG_H       = DEFAULT_IMG_H,
  parameter int SKIP_FRAMES = DEFAULT_SKIP_FRAMES
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_init_done,
  input  logic        cmos_vsync,
  input  logic        cmos_href,
  input  logic [7:0]  cmos_db,
  output logic        vsync,
  output logic        de,
  output logic        half_cmos_clk,
  output logic [15:0] data_bgr565,
  output logic [23:0] data_bgr888,
  output logic [15:0] o_frame_cnt,
  output logic        o_line_err
);

  localparam int              SKIP_W          = $clog2(SKIP_FRAMES + 2);
  localparam logic [SKIP_W-1:0] SKIP_LAST     = SKIP_W'(SKIP_FRAMES);
  localparam logic [15:0]     PIX_PER_LINE    = 16'(IMG_W);
  localparam logic [15:0]     LINES_PER_FRAME = 16'(IMG_H);

  logic              init_s, vsync_s, href_s;
  logic [7:0]        db_s;
  logic              vsync_d, href_act_d;
  logic              enable_reg;
  logic [SKIP_W-1:0] skip_cnt;
  logic              phase;
  logic [7:0]        hi_byte;
  logic [15:0]       pix_cnt, line_cnt;

  logic        href_act, vsync_rise, href_fall;
  logic        en_set, en_now, capture_lo, line_bad, frame_bad;
  logic [15:0] word;

  // href is only meaningful outside the vertical blanking pulse.
  always_comb begin
    href_act   = href_s & ~vsync_s;
    vsync_rise = vsync_s & ~vsync_d;
    href_fall  = href_act_d & ~href_act;
    en_set     = ~enable_reg & init_s & vsync_rise & (skip_cnt == SKIP_LAST);
    en_now     = enable_reg | en_set;
    capture_lo = href_act & phase;
    word       = {hi_byte, db_s};
    line_bad   = href_fall & ((pix_cnt != PIX_PER_LINE) | phase);
    frame_bad  = vsync_rise & (line_cnt != 16'd0) & (line_cnt != LINES_PER_FRAME);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      init_s        <= 1'b0;
      vsync_s       <= 1'b0;
      href_s        <= 1'b0;
      db_s          <= 8'd0;
      vsync_d       <= 1'b0;
      href_act_d    <= 1'b0;
      enable_reg    <= 1'b0;
      skip_cnt      <= '0;
      phase         <= 1'b0;
      hi_byte       <= 8'd0;
      pix_cnt       <= 16'd0;
      line_cnt      <= 16'd0;
      vsync         <= 1'b0;
      de            <= 1'b0;
      half_cmos_clk <= 1'b0;
      data_bgr565   <= 16'd0;
      data_bgr888   <= 24'd0;
      o_frame_cnt   <= 16'd0;
      o_line_err    <= 1'b0;
    end else begin
      init_s        <= i_init_done;
      vsync_s       <= cmos_vsync;
      href_s        <= cmos_href;
      db_s          <= cmos_db;
      vsync_d       <= vsync_s;
      href_act_d    <= href_act;
      half_cmos_clk <= ~half_cmos_clk;

      if (en_set)
        enable_reg <= 1'b1;
      if (~enable_reg & init_s & vsync_rise & ~en_set)
        skip_cnt <= skip_cnt + SKIP_W'(1);

      vsync <= en_now & vsync_s;

      phase <= href_act ? ~phase : 1'b0;
      if (href_act & ~phase)
        hi_byte <= db_s;

      de <= enable_reg & capture_lo;
      if (enable_reg & capture_lo) begin
        data_bgr565 <= word;
        data_bgr888 <= rgb565_to_888(word);
        if (pix_cnt != 16'hFFFF)
          pix_cnt <= pix_cnt + 16'd1;
      end

      // A leftover odd byte is simply dropped; only the error flag records it.
      if (enable_reg & href_fall) begin
        line_cnt <= line_cnt + 16'd1;
        pix_cnt  <= 16'd0;
        if (line_bad)
          o_line_err <= 1'b1;
      end

      if (en_now & vsync_rise) begin
        o_frame_cnt <= o_frame_cnt + 16'd1;
        line_cnt    <= 16'd0;
        pix_cnt     <= 16'd0;
        o_line_err  <= frame_bad | (enable_reg & line_bad);
      end
    end
  end

endmodule

// File: tb/tb_cam_pixel_capture.sv
// Randomized bench for cam_pixel_capture with a frame/line level reference model.
// Small geometry (4x2, one skip frame) keeps every scenario short.
module tb_cam_pixel_capture;

  localparam int IMG_W = 4;
  localparam int IMG_H = 2;
  localparam int SKIP  = 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_init_done = 1'b0;
  logic        cmos_vsync = 1'b0;
  logic        cmos_href = 1'b0;
  logic [7:0]  cmos_db = 8'd0;
  logic        vsync, de, half_cmos_clk, o_line_err;
  logic [15:0] data_bgr565, o_frame_cnt;
  logic [23:0] data_bgr888;

  cam_pixel_capture #(.IMG_W(IMG_W), .IMG_H(IMG_H), .SKIP_FRAMES(SKIP)) dut (
    .clk(clk), .rst_n(rst_n), .i_init_done(i_init_done),
    .cmos_vsync(cmos_vsync), .cmos_href(cmos_href), .cmos_db(cmos_db),
    .vsync(vsync), .de(de), .half_cmos_clk(half_cmos_clk),
    .data_bgr565(data_bgr565), .data_bgr888(data_bgr888),
    .o_frame_cnt(o_frame_cnt), .o_line_err(o_line_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model state, tracked per frame and per line.
  bit          m_init = 1'b0;
  int          m_edges = 0;
  bit          m_en = 1'b0;
  int          m_lines = 0;
  int          m_frame = 0;
  bit          m_err = 1'b0;
  logic [39:0] exp_q[$];
  logic [39:0] obs_q[$];
  logic [39:0] last_obs[$];
  logic [7:0]  line_bytes[$];

  int   vs_hi = 0;
  int   tog_bad = 0;
  bit   have_prev = 1'b0;
  logic prev_half = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      have_prev = 1'b0;
    end else begin
      if (de) obs_q.push_back({data_bgr565, data_bgr888});
      if (vsync) vs_hi++;
      if (have_prev && half_cmos_clk == prev_half) tog_bad++;
      prev_half = half_cmos_clk;
      have_prev = 1'b1;
    end
  end

  function automatic logic [39:0] model_pixel(input logic [7:0] hi, input logic [7:0] lo);
    int w, r, g, b;
    w = hi * 256 + lo;
    r = w / 2048;
    g = (w / 32) % 64;
    b = w % 32;
    return {16'(w), 8'(r * 8 + r / 4), 8'(g * 4 + g / 16), 8'(b * 8 + b / 4)};
  endfunction

  task automatic fill_random(input int n);
    line_bytes.delete();
    repeat (n) line_bytes.push_back(8'($urandom_range(0, 255)));
  endtask

  task automatic send_line();
    int n;
    n = line_bytes.size();
    foreach (line_bytes[i]) begin
      @(negedge clk);
      cmos_href = 1'b1;
      cmos_db   = line_bytes[i];
    end
    @(negedge clk);
    cmos_href = 1'b0;
    cmos_db   = 8'($urandom_range(0, 255));
    repeat (4) @(negedge clk);
    if (m_en) begin
      for (int i = 0; i + 1 < n; i += 2)
        exp_q.push_back(model_pixel(line_bytes[i], line_bytes[i + 1]));
      m_lines++;
      if (n != 2 * IMG_W) m_err = 1'b1;
    end
    #1;
    check_eq("de_count", obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      check_eq("pix565", obs_q[i][39:24], exp_q[i][39:24]);
      check_eq("pix888", obs_q[i][23:0], exp_q[i][23:0]);
    end
    check_eq("line_err", o_line_err, m_err);
    $display("line: %0d bytes, %0d pixels, line_err=%0b", n, obs_q.size(), o_line_err);
    last_obs = obs_q;
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic vsync_pulse(input bit with_href);
    vs_hi = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      cmos_vsync = 1'b1;
      cmos_href  = with_href && (c == 1 || c == 2);
      cmos_db    = 8'($urandom_range(0, 255));
    end
    @(negedge clk);
    cmos_vsync = 1'b0;
    cmos_href  = 1'b0;
    repeat (4) @(negedge clk);
    if (m_init) begin
      m_edges++;
      if (m_edges > SKIP) m_en = 1'b1;
    end
    if (m_en) begin
      m_frame = (m_frame + 1) % 65536;
      m_err   = (m_lines != 0) && (m_lines != IMG_H);
      m_lines = 0;
    end
    #1;
    check_eq("vsync_cycles", vs_hi, m_en ? 4 : 0);
    check_eq("frame_cnt", o_frame_cnt, m_frame);
    check_eq("frame_err", o_line_err, m_err);
    check_eq("de_in_vsync", obs_q.size(), 0);
    $display("frame: vsync_cycles=%0d frame_cnt=%0d line_err=%0b", vs_hi, o_frame_cnt, o_line_err);
    obs_q.delete();
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_vsync"}, vsync, 0);
    check_eq({tag, "_de"}, de, 0);
    check_eq({tag, "_half"}, half_cmos_clk, 0);
    check_eq({tag, "_565"}, data_bgr565, 0);
    check_eq({tag, "_888"}, data_bgr888, 0);
    check_eq({tag, "_frame"}, o_frame_cnt, 0);
    check_eq({tag, "_err"}, o_line_err, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "timeout");
  end

  initial begin
    logic [23:0] ref888 [4];
    int nl, r;
    ref888[0] = 24'hFF0000;
    ref888[1] = 24'h00FF00;
    ref888[2] = 24'h0000FF;
    ref888[3] = 24'hFFFFFF;

    repeat (3) @(negedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Sensor not initialised: frames must be ignored entirely.
    repeat (3) begin
      vsync_pulse(1'b0);
      repeat (IMG_H) begin
        fill_random(2 * IMG_W);
        send_line();
      end
    end

    i_init_done = 1'b1;
    m_init = 1'b1;
    repeat (3) @(negedge clk);
    vsync_pulse(1'b0);
    fill_random(2 * IMG_W);
    send_line();
    vsync_pulse(1'b0);

    line_bytes = '{8'hF8, 8'h00, 8'h07, 8'hE0, 8'h00, 8'h1F, 8'hFF, 8'hFF};
    send_line();
    for (int i = 0; i < last_obs.size() && i < 4; i++)
      check_eq("fixed888", last_obs[i][23:0], ref888[i]);
    fill_random(2 * IMG_W);
    send_line();
    vsync_pulse(1'b1);

    fill_random(2 * IMG_W);
    send_line();
    fill_random(2 * IMG_W - 1);
    send_line();
    vsync_pulse(1'b0);

    repeat (3) begin
      fill_random(2 * IMG_W);
      send_line();
    end
    vsync_pulse(1'b0);
    repeat (IMG_H) begin
      fill_random(2 * IMG_W);
      send_line();
    end
    vsync_pulse(1'b0);

    repeat (8) begin
      nl = $urandom_range(1, 3);
      repeat (nl) begin
        r = $urandom_range(0, 5);
        fill_random(r == 0 ? 7 : r == 1 ? 9 : r == 2 ? 6 : 8);
        send_line();
      end
      vsync_pulse(1'($urandom_range(0, 1)));
    end

    // Reset in the middle of a line.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      cmos_href = 1'b1;
      cmos_db   = 8'($urandom_range(1, 255));
    end
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    @(negedge clk);
    cmos_href = 1'b0;
    m_en = 1'b0;
    m_edges = 0;
    m_frame = 0;
    m_err = 1'b0;
    m_lines = 0;
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    obs_q.delete();
    repeat (2) @(negedge clk);
    vsync_pulse(1'b0);
    fill_random(2 * IMG_W);
    send_line();
    vsync_pulse(1'b0);
    fill_random(2 * IMG_W);
    send_line();

    check_eq("half_clk_toggle", tog_bad, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
